// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the serial_bus arbiter slice.
// Master IDs double as the round-robin pointer encoding.
package serial_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M1 = 2'd1,
        OWN_M2 = 2'd2,
        RESUME = 2'd3
    } arb_state_t;

    localparam logic MID_M1 = 1'b0;
    localparam logic MID_M2 = 1'b1;

    localparam int unsigned HOLD_MAX_DEF = 1024;

    typedef struct packed {
        logic m1_bgrant;
        logic m2_bgrant;
        logic m1_ack;
        logic m2_ack;
        logic m1_split;
        logic m2_split;
        logic s3_split_grant;
        logic bus_busy;
        logic hold_timeout;
    } arb_out_t;

    // One-hot request mask bit for a master ID: bit 0 = m1, bit 1 = m2.
    function automatic logic [1:0] mid_mask(input logic id);
        return (id == MID_M2) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/serial_bus_arbiter_if.sv
// Handshake signals between the serial_bus masters/slave and the arbiter.
// master: the bus agents' view; slave: the arbiter's view.
interface serial_bus_arbiter_if;

    logic m1_breq;
    logic m2_breq;
    logic m1_bgrant;
    logic m2_bgrant;
    logic m1_ack;
    logic m2_ack;
    logic m1_split;
    logic m2_split;
    logic s3_split;
    logic s3_split_ready;
    logic s3_split_grant;
    logic bus_busy;
    logic hold_timeout;

    modport master (
        output m1_breq, m2_breq, s3_split, s3_split_ready,
        input  m1_bgrant, m2_bgrant, m1_ack, m2_ack, m1_split, m2_split,
        input  s3_split_grant, bus_busy, hold_timeout
    );

    modport slave (
        input  m1_breq, m2_breq, s3_split, s3_split_ready,
        output m1_bgrant, m2_bgrant, m1_ack, m2_ack, m1_split, m2_split,
        output s3_split_grant, bus_busy, hold_timeout
    );

endinterface

// File: rtl/serial_bus_arbiter_arb_pick.sv
// Combinational winner select between the two masters.
// ARB_ROUND_ROBIN_EN selects round-robin on contention; default is fixed m1-first priority.
module arb_pick
    import serial_bus_pkg::*;
(
    input  logic       req1,
    input  logic       req2,
    input  logic       rr_ptr,
    input  logic [1:0] mask,
    output logic       valid,
    output logic       win_id
);

    logic c1;
    logic c2;

    assign c1    = req1 & ~mask[0];
    assign c2    = req2 & ~mask[1];
    assign valid = c1 | c2;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_ptr names the master that did not win most recently.
    always_comb begin
        win_id = MID_M1;
        if (c1 && c2) win_id = rr_ptr;
        else if (c2)  win_id = MID_M2;
    end
`else
    logic rr_ptr_unused;
    assign rr_ptr_unused = rr_ptr;

    always_comb begin
        win_id = MID_M1;
        if (!c1 && c2) win_id = MID_M2;
    end
`endif

endmodule

// File: rtl/serial_bus_arbiter.sv
// Bus ownership FSM for two masters and a split-capable slave, with hold limit.
// Contention policy comes from arb_pick (ARB_ROUND_ROBIN_EN).
module serial_bus_arbiter
    import serial_bus_pkg::*;
#(
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEF,
    parameter int unsigned HOLD_W   = 11
) (
    input  logic                 clk,
    input  logic                 rstn,
    serial_bus_arbiter_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    arb_state_t        state, state_nxt;
    logic              split_pend, split_pend_nxt;
    logic              split_id, split_id_nxt;
    logic              rr_ptr, rr_ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              timeout_nxt;
    arb_out_t          out_q, out_d;

    logic              owner_id;
    logic              owner_req;
    logic [1:0]        park_mask;
    logic              other_req;
    logic [1:0]        pick_mask;
    logic              pick_valid;
    logic              pick_id;

    // A master released by the hold limit yields the very next contest if the
    // other master is waiting; rr_ptr is the inverse of the last OWN winner.
    always_comb begin
        park_mask = split_pend ? mid_mask(split_id) : 2'b00;
        other_req = (rr_ptr == MID_M1) ? (bus.m1_breq & ~park_mask[0])
                                       : (bus.m2_breq & ~park_mask[1]);
        pick_mask = park_mask;
        if (out_q.hold_timeout && other_req) pick_mask = park_mask | mid_mask(~rr_ptr);
    end

    arb_pick u_arb_pick (
        .req1   (bus.m1_breq),
        .req2   (bus.m2_breq),
        .rr_ptr (rr_ptr),
        .mask   (pick_mask),
        .valid  (pick_valid),
        .win_id (pick_id)
    );

    assign owner_id  = (state == OWN_M2) ? MID_M2 : MID_M1;
    assign owner_req = (state == OWN_M2) ? bus.m2_breq : bus.m1_breq;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            split_pend <= 1'b0;
            split_id   <= MID_M1;
            rr_ptr     <= MID_M1;
            hold_cnt   <= '0;
            out_q      <= '0;
        end else begin
            state      <= state_nxt;
            split_pend <= split_pend_nxt;
            split_id   <= split_id_nxt;
            rr_ptr     <= rr_ptr_nxt;
            hold_cnt   <= hold_cnt_nxt;
            out_q      <= out_d;
        end
    end

    always_comb begin
        state_nxt      = state;
        split_pend_nxt = split_pend;
        split_id_nxt   = split_id;
        rr_ptr_nxt     = rr_ptr;
        timeout_nxt    = 1'b0;
        hold_cnt_nxt   = hold_cnt;

        if (state == IDLE)        hold_cnt_nxt = '0;
        else if (hold_cnt != '1)  hold_cnt_nxt = hold_cnt + 1'b1;

        unique case (state)
            IDLE: begin
                if (split_pend && bus.s3_split_ready) begin
                    state_nxt = RESUME;
                end else if (pick_valid) begin
                    state_nxt  = (pick_id == MID_M1) ? OWN_M1 : OWN_M2;
                    rr_ptr_nxt = ~pick_id;
                end
            end
            OWN_M1, OWN_M2: begin
                if (bus.s3_split && !split_pend) begin
                    state_nxt      = IDLE;
                    split_pend_nxt = 1'b1;
                    split_id_nxt   = owner_id;
                end else if (!owner_req) begin
                    state_nxt = IDLE;
                end else if (HOLD_MAX != 0 && hold_cnt == HOLD_LAST) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            RESUME: begin
                if (!bus.s3_split_ready) begin
                    state_nxt      = IDLE;
                    split_pend_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_d                = '0;
        out_d.m1_bgrant      = (state_nxt == OWN_M1) ||
                               (state_nxt == RESUME && split_id_nxt == MID_M1);
        out_d.m2_bgrant      = (state_nxt == OWN_M2) ||
                               (state_nxt == RESUME && split_id_nxt == MID_M2);
        out_d.m1_ack         = (state_nxt == OWN_M1) && (state == IDLE);
        out_d.m2_ack         = (state_nxt == OWN_M2) && (state == IDLE);
        out_d.m1_split       = split_pend_nxt && (split_id_nxt == MID_M1);
        out_d.m2_split       = split_pend_nxt && (split_id_nxt == MID_M2);
        out_d.s3_split_grant = (state_nxt == RESUME);
        out_d.bus_busy       = (state_nxt != IDLE);
        out_d.hold_timeout   = timeout_nxt;
    end

    assign bus.m1_bgrant      = out_q.m1_bgrant;
    assign bus.m2_bgrant      = out_q.m2_bgrant;
    assign bus.m1_ack         = out_q.m1_ack;
    assign bus.m2_ack         = out_q.m2_ack;
    assign bus.m1_split       = out_q.m1_split;
    assign bus.m2_split       = out_q.m2_split;
    assign bus.s3_split_grant = out_q.s3_split_grant;
    assign bus.bus_busy       = out_q.bus_busy;
    assign bus.hold_timeout   = out_q.hold_timeout;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Self-checking bench for serial_bus_arbiter with a cycle-level ownership model.
// Honours ARB_ROUND_ROBIN_EN when deciding contention expectations.
module tb_serial_bus_arbiter;

    localparam int HOLD = 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    serial_bus_arbiter_if bus();

    serial_bus_arbiter #(.HOLD_MAX(HOLD), .HOLD_W(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model: own 0 = nobody, 1 = m1, 2 = m2, 3 = slave resuming for parked master pid.
    int own = 0, pid = 1, hold = 0, last = 2, yield_id = 0;
    bit pend = 0, ack1 = 0, ack2 = 0, tmo = 0;

    task automatic model_step();
        int  prev_yield, win;
        bit  c1, c2, req;
        if (!rstn) begin
            own = 0; pend = 0; pid = 1; hold = 0; last = 2;
            yield_id = 0; ack1 = 0; ack2 = 0; tmo = 0;
            return;
        end
        ack1 = 0; ack2 = 0; tmo = 0;
        prev_yield = yield_id;
        yield_id = 0;
        case (own)
            0: begin
                if (pend && bus.s3_split_ready) begin
                    own = 3;
                end else begin
                    c1 = bus.m1_breq && !(pend && pid == 1);
                    c2 = bus.m2_breq && !(pend && pid == 2);
                    if (prev_yield == 1 && c2) c1 = 0;
                    if (prev_yield == 2 && c1) c2 = 0;
                    win = 0;
                    if (c1 && c2)  win = RR ? ((last == 1) ? 2 : 1) : 1;
                    else if (c1)   win = 1;
                    else if (c2)   win = 2;
                    if (win != 0) begin
                        own = win; hold = 0; last = win;
                        if (win == 1) ack1 = 1; else ack2 = 1;
                    end
                end
            end
            1, 2: begin
                req = (own == 1) ? bus.m1_breq : bus.m2_breq;
                if (bus.s3_split && !pend) begin
                    pend = 1; pid = own; own = 0;
                end else if (!req) begin
                    own = 0;
                end else if (hold == HOLD - 1) begin
                    tmo = 1; yield_id = own; own = 0;
                end else begin
                    hold++;
                end
            end
            default: begin
                if (!bus.s3_split_ready) begin own = 0; pend = 0; end
            end
        endcase
    endtask

    function automatic logic [8:0] exp_vec();
        return {own == 1 || (own == 3 && pid == 1), own == 2 || (own == 3 && pid == 2),
                ack1, ack2, pend && pid == 1, pend && pid == 2, own == 3, own != 0, tmo};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {bus.m1_bgrant, bus.m2_bgrant, bus.m1_ack, bus.m2_ack, bus.m1_split,
                bus.m2_split, bus.s3_split_grant, bus.bus_busy, bus.hold_timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        bus.m1_breq = 0; bus.m2_breq = 0; bus.s3_split = 0; bus.s3_split_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 0;
        tick(); tick();
        rstn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (dut_vec() !== 9'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b exp %b", dut_vec(), 9'b0);
        end
        tick();
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_idle: got %b exp %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_basic_grant();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            bus.m1_breq = (i <= 7);
            tick();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL basic_grant cyc %0d: got %b exp %b", i, dut_vec(), exp_vec());
            end
            if (i == 1) begin
                n_cmp++;
                if ({bus.m1_bgrant, bus.m1_ack, bus.bus_busy} !== 3'b111) begin
                    n_fail++; $display("FAIL basic_first: got %b exp 111", {bus.m1_bgrant, bus.m1_ack, bus.bus_busy});
                end
            end
            if (i == 2) begin
                n_cmp++;
                if ({bus.m1_bgrant, bus.m1_ack} !== 2'b10) begin
                    n_fail++; $display("FAIL basic_ack_pulse: got %b exp 10", {bus.m1_bgrant, bus.m1_ack});
                end
            end
            if (i == 8) begin
                n_cmp++;
                if ({bus.m1_bgrant, bus.bus_busy} !== 2'b00) begin
                    n_fail++; $display("FAIL basic_release: got %b exp 00", {bus.m1_bgrant, bus.bus_busy});
                end
            end
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            bus.m1_breq = (i != 4);
            bus.m2_breq = 1;
            tick();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL contention cyc %0d: got %b exp %b", i, dut_vec(), exp_vec());
            end
            if (i == 1) begin
                n_cmp++;
                if ({bus.m1_bgrant, bus.m2_bgrant} !== 2'b10) begin
                    n_fail++; $display("FAIL contention_first: got %b exp 10", {bus.m1_bgrant, bus.m2_bgrant});
                end
            end
            if (i == 5) begin
                n_cmp++;
                if ({bus.m1_bgrant, bus.m2_bgrant} !== (RR ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL contention_second: got %b exp %b", {bus.m1_bgrant, bus.m2_bgrant}, RR ? 2'b01 : 2'b10);
                end
            end
        end
    endtask

    task automatic test_split_resume();
        logic [8:0] want [1:9];
        // Columns: m1g m2g m1a m2a m1s m2s sgnt busy tmo
        want[1] = 9'b010100010;  // m2 granted
        want[2] = 9'b010000010;
        want[3] = 9'b000001000;  // split: m2 parked
        want[4] = 9'b101001010;  // m1 owns
        want[5] = 9'b100001010;  // ready ignored while m1 owns
        want[6] = 9'b100001010;
        want[7] = 9'b000001000;  // m1 drops
        want[8] = 9'b010001110;  // resume
        want[9] = 9'b000000000;  // ready falls
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            bus.m2_breq        = (i <= 6);
            bus.s3_split       = (i == 3);
            bus.m1_breq        = (i >= 4 && i <= 6);
            bus.s3_split_ready = (i >= 5 && i <= 8);
            tick();
            n_cmp++;
            if (dut_vec() !== want[i] || dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL split_resume cyc %0d: got %b exp %b", i, dut_vec(), want[i]);
            end
        end
    endtask

    task automatic test_hold_timeout();
        int grants = 0;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            bus.m1_breq = 1;
            bus.m2_breq = (i >= 2 && i <= 11);
            tick();
            if (i <= 9 && bus.m1_bgrant === 1'b1) grants++;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL hold cyc %0d: got %b exp %b", i, dut_vec(), exp_vec());
            end
            if (i == 9) begin
                n_cmp++;
                if ({bus.m1_bgrant, bus.hold_timeout, grants[3:0]} !== {2'b01, 4'd8}) begin
                    n_fail++; $display("FAIL hold_release: got %b/%0d exp 01/8", {bus.m1_bgrant, bus.hold_timeout}, grants);
                end
            end
            if (i == 10) begin
                n_cmp++;
                if ({bus.m2_bgrant, bus.m2_ack, bus.hold_timeout} !== 3'b110) begin
                    n_fail++; $display("FAIL hold_m2_grant: got %b exp 110", {bus.m2_bgrant, bus.m2_ack, bus.hold_timeout});
                end
            end
        end
    endtask

    task automatic test_split_drop_and_reset();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            bus.m1_breq        = (i <= 2);
            bus.s3_split       = (i == 3);
            bus.s3_split_ready = (i >= 5);
            rstn               = (i != 7);
            tick();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL split_drop cyc %0d: got %b exp %b", i, dut_vec(), exp_vec());
            end
        end
        do_reset();
        bus.m1_breq = 1;
        tick(); tick();
        bus.s3_split = 1;
        bus.m1_breq  = 0;
        tick();
        bus.s3_split = 0;
        n_cmp++;
        if ({bus.m1_split, bus.m1_bgrant} !== 2'b10) begin
            n_fail++; $display("FAIL split_wins_drop: got %b exp 10", {bus.m1_split, bus.m1_bgrant});
        end
        bus.s3_split_ready = 1;
        tick(); tick();
        n_cmp++;
        if ({bus.s3_split_grant, bus.m1_bgrant, bus.m1_ack} !== 3'b110) begin
            n_fail++; $display("FAIL drop_resume: got %b exp 110", {bus.s3_split_grant, bus.m1_bgrant, bus.m1_ack});
        end
        rstn = 0;
        tick();
        rstn = 1;
        n_cmp++;
        if (dut_vec() !== 9'b0) begin
            n_fail++; $display("FAIL reset_in_resume: got %b exp %b", dut_vec(), 9'b0);
        end
        tick(); tick();
        n_cmp++;
        if (dut_vec() !== 9'b0 || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL stale_ready: got %b exp %b", dut_vec(), 9'b0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) bus.m1_breq = ~bus.m1_breq;
            if ($urandom_range(0, 5) == 0) bus.m2_breq = ~bus.m2_breq;
            if ($urandom_range(0, 9) == 0) bus.s3_split_ready = ~bus.s3_split_ready;
            bus.s3_split = ($urandom_range(0, 11) == 0);
            rstn = ($urandom_range(0, 299) != 0);
            tick();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc %0d: got %b exp %b", i, dut_vec(), exp_vec());
            end
        end
        rstn = 1;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic_grant();
        test_contention();
        test_split_resume();
        test_hold_timeout();
        test_split_drop_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
